// File: rtl/uart_rx_os_if.sv
// Receive-word handshake between uart_rx_os and the RX FIFO write side.
// The receiver is the master; the FIFO side supplies rx_ready.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote per bit.
// Optional parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    uart_rx_os_if.master rx_if,
    output logic         overrun,
    output logic         busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV) + 1;
    localparam int OW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int M       = OVERSAMPLE / 2;

`ifdef UART_RX_PARITY_EN
    localparam logic PODD = (PARITY_ODD != 0);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state, nxt;

    logic                 sync1, sync2, prev;
    logic [DW-1:0]        div_cnt;
    logic [OW-1:0]        os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 perr_bit;

    logic fall, tick, at_vote, at_end, vote;
    logic start_det, done;

    assign fall    = prev & ~sync2;
    assign tick    = (state != IDLE) && (div_cnt == DW'(DIV - 1));
    assign at_vote = tick && (os_cnt == OW'(M + 1));
    assign at_end  = tick && (os_cnt == OW'(OVERSAMPLE - 1));
    assign vote    = (smp[1] & smp[0]) | (smp[1] & sync2) | (smp[0] & sync2);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Last stop vote returns to IDLE mid-bit so the next start edge is seen early.
    always_comb begin
        nxt       = state;
        start_det = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    nxt       = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (at_vote && vote) nxt = IDLE;
                else if (at_end)     nxt = DATA;
            end
            DATA: begin
                if (at_end && bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    nxt = PARITY;
`else
                    nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_end) nxt = STOP;
            end
`endif
            STOP: begin
                if (at_vote && stop_cnt == 1'(STOP_BITS - 1)) begin
                    nxt  = IDLE;
                    done = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            prev     <= 1'b1;
            div_cnt  <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            smp      <= '0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
            perr_bit <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
            if (start_det) begin
                div_cnt  <= '0;
                os_cnt   <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                ferr_acc <= 1'b0;
                perr_bit <= 1'b0;
            end else if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) os_cnt <= at_end ? '0 : os_cnt + 1'b1;
                if (tick && os_cnt == OW'(M - 1)) smp[1] <= sync2;
                if (tick && os_cnt == OW'(M))     smp[0] <= sync2;
                if (at_vote && state == DATA)
                    shreg <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                if (at_vote && state == PARITY)
                    perr_bit <= vote ^ (^shreg) ^ PODD;
`endif
                if (at_vote && state == STOP && !vote) ferr_acc <= 1'b1;
                if (at_end && state == DATA) bit_cnt <= bit_cnt + 1'b1;
                if (at_end && state == STOP) stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

    // Output word register; a completion that finds it full and unaccepted is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_if.rx_data    <= '0;
            rx_if.rx_valid   <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.parity_err <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (rx_if.rx_valid && !rx_if.rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_if.rx_data    <= shreg;
                    rx_if.frame_err  <= ferr_acc | ~vote;
                    rx_if.parity_err <= perr_bit;
                    rx_if.rx_valid   <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at 16 clocks per bit.
// Parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    localparam int BT  = 16;
    localparam int LAT = 4 + (1 + DB + NP) * BT + BT / 2 + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic overrun, busy;

    uart_rx_os_if #(.DATA_BITS(DB)) rif ();

    uart_rx_os #(
        .CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16),
        .DATA_BITS(DB), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_if(rif),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         cyc;
    } word_t;

    word_t exp_q[$];
    word_t obs_q[$];
    int errors = 0, checks = 0;
    int cyc = 0, ovr_cnt = 0, last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && rif.rx_valid && rif.rx_ready)
            obs_q.push_back('{rif.rx_data, rif.frame_err, rif.parity_err, cyc});
        if (overrun) ovr_cnt++;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (BT - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pflip);
        @(negedge clk);
        rx = 1'b0;
        last_start = cyc;
        repeat (BT - 1) @(negedge clk);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (NP != 0) send_bit((^d) ^ pflip);
        send_bit(stop_v);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rif.rx_valid); end
        checks++;
        if (rif.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rif.rx_data); end
        checks++;
        if (rif.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", rif.frame_err); end
        checks++;
        if (rif.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", rif.parity_err); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        idle(BT);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        logic [7:0] pats [6];
        logic [7:0] d;
        word_t e, o;
        int o0;
        pats = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h01, 8'h80};
        rif.rx_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            d = (i < 6) ? pats[i] : 8'($urandom_range(0, 255));
            o0 = ovr_cnt;
            exp_q.push_back('{d, 1'b0, 1'b0, 0});
            send_frame(d, 1'b1, 1'b0);
            idle(8);
            checks++;
            if (obs_q.size() != 1) begin
                errors++;
                $display("FAIL basic_count[%0d] got %0d want 1", i, obs_q.size());
                obs_q.delete();
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o.d !== e.d) begin errors++; $display("FAIL basic_data got %h want %h", o.d, e.d); end
                checks++;
                if (o.fe !== e.fe) begin errors++; $display("FAIL basic_ferr got %b want %b", o.fe, e.fe); end
                checks++;
                if (o.pe !== e.pe) begin errors++; $display("FAIL basic_perr got %b want %b", o.pe, e.pe); end
                if (i == 0) begin
                    checks++;
                    if (o.cyc - last_start != LAT) begin
                        errors++;
                        $display("FAIL basic_latency got %0d want %0d", o.cyc - last_start, LAT);
                    end
                end
            end
            checks++;
            if (ovr_cnt != o0) begin errors++; $display("FAIL basic_overrun got %0d want %0d", ovr_cnt, o0); end
            checks++;
            if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", rif.rx_valid); end
        end
    endtask

    task automatic test_break;
        word_t e, o;
        rif.rx_ready = 1'b1;
        exp_q.push_back('{8'h3C, 1'b1, 1'b0, 0});
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 * BT) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL break_count got %0d want 1", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d) begin errors++; $display("FAIL break_data got %h want %h", o.d, e.d); end
            checks++;
            if (o.fe !== e.fe) begin errors++; $display("FAIL break_ferr got %b want %b", o.fe, e.fe); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b want 0", busy); end
        idle(2 * BT);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL break_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
        exp_q.push_back('{8'h55, 1'b0, 1'b0, 0});
        send_frame(8'h55, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL break_resume_count got %0d want 1", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.fe !== e.fe) begin
                errors++;
                $display("FAIL break_resume got %h/%b want %h/%b", o.d, o.fe, e.d, e.fe);
            end
        end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b want 1", busy); end
        repeat (BT) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got %b want 0", busy); end
        idle(2 * BT);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_word got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_overrun;
        word_t e, o;
        int o0;
        rif.rx_ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back('{8'h11, 1'b0, 1'b0, 0});
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (rif.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", rif.rx_valid); end
        checks++;
        if (rif.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_hold_data got %h want 11", rif.rx_data); end
        checks++;
        if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
        @(posedge clk);
        #1 rif.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL ovr_accept_count got %0d want 1", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d) begin errors++; $display("FAIL ovr_accept_data got %h want %h", o.d, e.d); end
        end
        checks++;
        if (rif.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear got %b want 0", rif.rx_valid); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        word_t e, o;
        rif.rx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{8'h07, 1'b0, (k == 0), 0});
            send_frame(8'h07, 1'b1, (k == 0));
            idle(8);
            checks++;
            if (obs_q.size() != 1) begin
                errors++;
                $display("FAIL parity_count[%0d] got %0d want 1", k, obs_q.size());
                obs_q.delete();
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o.d !== e.d) begin errors++; $display("FAIL parity_data got %h want %h", o.d, e.d); end
                checks++;
                if (o.pe !== e.pe) begin errors++; $display("FAIL parity_err got %b want %b", o.pe, e.pe); end
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [7:0] d;
        word_t e, o;
        d = 8'h5A;
        rif.rx_ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (rif.rx_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", rif.rx_valid); end
        @(negedge clk);
        rx = 1'b0;
        repeat (BT - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        @(negedge clk);
        rx = d[4];
        repeat (BT / 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", busy); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rif.rx_valid !== 1'b0 || rif.rx_data !== 8'h00 || rif.frame_err !== 1'b0 ||
            rif.parity_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b d=%h fe=%b pe=%b ov=%b busy=%b want all 0",
                     rif.rx_valid, rif.rx_data, rif.frame_err, rif.parity_err, overrun, busy);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle(BT);
        rif.rx_ready = 1'b1;
        idle(4);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rst_partial got %0d want 0", obs_q.size()); obs_q.delete(); end
        exp_q.push_back('{d, 1'b0, 1'b0, 0});
        send_frame(d, 1'b1, 1'b0);
        idle(2 * BT);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL rst_after_count got %0d want 1", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.fe !== e.fe) begin
                errors++;
                $display("FAIL rst_after_data got %h/%b want %h/%b", o.d, o.fe, e.d, e.fe);
            end
        end
    endtask

    initial begin
        rif.rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_break();
        test_glitch();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
